// File: rtl/truss_multi_watchdog.sv
// truss_multi_watchdog: multi-channel kickable watchdog with post-timeout hang escalation.
// Each channel counts down from its reload value. A kick restarts the count, and expiry
// raises a sticky timeout. After expiry a post counter runs, and when it runs out the
// channel enters HUNG. HUNG is terminal until reset.
// Optional macro TRUSS_WATCHDOG_FINISH_EN: when any channel enters HUNG, print an error
// and end the simulation.

// One watchdog channel: reload register, main down-counter, post counter, state machine.
module truss_multi_watchdog_chan #(
  parameter int COUNT_WIDTH     = 32,
  parameter int POST_WIDTH      = 8,
  parameter int DEFAULT_TIMEOUT = 1000,
  parameter int POST_TIMEOUT    = 100
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_enable,
  input  logic                   i_kick,
  input  logic                   i_load,
  input  logic [COUNT_WIDTH-1:0] i_load_value,
  output logic                   o_timeout,
  output logic                   o_hung,
  output logic                   o_expire
);

  typedef enum logic [1:0] {S_DIS, S_CNT, S_EXP, S_HUNG} state_t;

  state_t                 r_state, w_state_nxt;
  logic [COUNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [COUNT_WIDTH-1:0] r_reload;
  logic [POST_WIDTH-1:0]  r_post, w_post_nxt;

  // State and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_DIS;
      r_cnt   <= '0;
      r_post  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_post  <= w_post_nxt;
    end
  end

  // Reload register. A kick on the same edge still sees the old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_reload <= COUNT_WIDTH'(DEFAULT_TIMEOUT);
    else if (i_load) r_reload <= i_load_value;
  end

  // Next state and counters. Within COUNT, disable beats kick, and kick beats expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_post_nxt  = r_post;
    case (r_state)
      S_DIS: begin
        if (i_enable) begin
          w_state_nxt = S_CNT;
          w_cnt_nxt   = r_reload;
        end
      end
      S_CNT: begin
        if (!i_enable) begin
          w_state_nxt = S_DIS;
          w_cnt_nxt   = '0;
        end else if (i_kick) begin
          w_cnt_nxt   = r_reload;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_EXP;
          w_post_nxt  = POST_WIDTH'(POST_TIMEOUT);
        end else begin
          w_cnt_nxt   = r_cnt - 1'b1;
        end
      end
      S_EXP: begin
        if (!i_enable)           w_state_nxt = S_DIS;
        else if (r_post == '0)   w_state_nxt = S_HUNG;
        else                     w_post_nxt  = r_post - 1'b1;
      end
      default: ; // HUNG holds until reset
    endcase
  end

  assign o_timeout = (r_state == S_EXP) || (r_state == S_HUNG);
  assign o_hung    = (r_state == S_HUNG);
  assign o_expire  = (r_state == S_CNT) && (w_state_nxt == S_EXP);

endmodule

// Top: per-channel instances, reload write decode, first-expiry capture, hang OR.
module truss_multi_watchdog #(
  parameter int CHANNELS        = 4,
  parameter int COUNT_WIDTH     = 32,
  parameter int POST_WIDTH      = 8,
  parameter int DEFAULT_TIMEOUT = 1000,
  parameter int POST_TIMEOUT    = 100,
  localparam int CHAN_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [CHANNELS-1:0]    enable,
  input  logic [CHANNELS-1:0]    kick,
  input  logic                   load_valid,
  input  logic [CHAN_W-1:0]      load_chan,
  input  logic [COUNT_WIDTH-1:0] load_value,
  output logic [CHANNELS-1:0]    timeout,
  output logic                   hang,
  output logic                   first_valid,
  output logic [CHAN_W-1:0]      first_chan
);

  logic [CHANNELS-1:0] w_hung;
  logic [CHANNELS-1:0] w_expire;
  logic                w_first_hit;
  logic [CHAN_W-1:0]   w_first_idx;
  logic                r_first_valid;
  logic [CHAN_W-1:0]   r_first_chan;

  // Indices at or above CHANNELS match no instance, so those writes are dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    truss_multi_watchdog_chan #(
      .COUNT_WIDTH    (COUNT_WIDTH),
      .POST_WIDTH     (POST_WIDTH),
      .DEFAULT_TIMEOUT(DEFAULT_TIMEOUT),
      .POST_TIMEOUT   (POST_TIMEOUT)
    ) u_chan (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_enable    (enable[i]),
      .i_kick      (kick[i]),
      .i_load      (load_valid && (load_chan == CHAN_W'(i))),
      .i_load_value(load_value),
      .o_timeout   (timeout[i]),
      .o_hung      (w_hung[i]),
      .o_expire    (w_expire[i])
    );

`ifdef TRUSS_WATCHDOG_FINISH_EN
    // Last-resort shutdown: the hang flag rises only on the entering clock edge.
    always @(posedge w_hung[i]) begin
      $display("ERROR: %0t %m: watchdog channel %0d hung", $time, i);
      $finish;
    end
`endif
  end

  // Lowest-index channel expiring on this edge.
  always_comb begin
    w_first_hit = 1'b0;
    w_first_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (w_expire[i]) begin
        w_first_hit = 1'b1;
        w_first_idx = CHAN_W'(i);
      end
    end
  end

  // Capture the first expiry since reset. It is held until the next reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_first_valid <= 1'b0;
      r_first_chan  <= '0;
    end else if (!r_first_valid && w_first_hit) begin
      r_first_valid <= 1'b1;
      r_first_chan  <= w_first_idx;
    end
  end

  assign hang        = |w_hung;
  assign first_valid = r_first_valid;
  assign first_chan  = r_first_chan;

endmodule

// File: tb/tb_truss_multi_watchdog.sv
// Bench for truss_multi_watchdog. Directed scenarios are followed by a random phase.
// The reference model works in absolute edge timestamps: when each channel is due to
// expire and when it is due to hang.
module tb_truss_multi_watchdog;

  localparam int CH   = 5;   // five channels, so load_chan 5..7 are out of range
  localparam int CW   = 32;
  localparam int PW   = 8;
  localparam int DEF  = 1000;
  localparam int POST = 100;
  localparam int CHW  = 3;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [CH-1:0]  en, kk;
  logic           lv;
  logic [CHW-1:0] lc;
  logic [CW-1:0]  lval;
  logic [CH-1:0]  timeout;
  logic           hang, first_valid;
  logic [CHW-1:0] first_chan;

  int n_checks = 0;
  int n_fail   = 0;

  truss_multi_watchdog #(
    .CHANNELS(CH), .COUNT_WIDTH(CW), .POST_WIDTH(PW),
    .DEFAULT_TIMEOUT(DEF), .POST_TIMEOUT(POST)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(en), .kick(kk),
    .load_valid(lv), .load_chan(lc), .load_value(lval),
    .timeout(timeout), .hang(hang), .first_valid(first_valid), .first_chan(first_chan)
  );

  always #5 clk = ~clk;

  // Reference model state
  longint n_edge;
  longint m_reload [CH];
  bit     m_on     [CH];
  bit     m_to     [CH];
  bit     m_hung   [CH];
  longint m_exp_at [CH];
  longint m_hang_at[CH];
  bit     m_fv;
  int     m_fc;

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_reload[c] = DEF; m_on[c] = 0; m_to[c] = 0; m_hung[c] = 0;
      m_exp_at[c] = 0;   m_hang_at[c] = 0;
    end
    m_fv = 0; m_fc = 0;
  endfunction

  function automatic void model_edge();
    int first = -1;
    for (int c = 0; c < CH; c++) begin
      if (m_hung[c]) begin
      end else if (m_to[c]) begin
        if (!en[c]) begin m_to[c] = 0; m_on[c] = 0; end
        else if (n_edge == m_hang_at[c]) m_hung[c] = 1;
      end else if (m_on[c]) begin
        if (!en[c]) m_on[c] = 0;
        else if (kk[c]) m_exp_at[c] = n_edge + m_reload[c] + 1;
        else if (n_edge == m_exp_at[c]) begin
          m_to[c] = 1;
          m_hang_at[c] = n_edge + POST + 1;
          if (first < 0) first = c;
        end
      end else if (en[c]) begin
        m_on[c] = 1;
        m_exp_at[c] = n_edge + m_reload[c] + 1;
      end
    end
    if (!m_fv && first >= 0) begin m_fv = 1; m_fc = first; end
    if (lv && int'(lc) < CH) m_reload[lc] = longint'(lval);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, exp, n_edge);
    end
  endtask

  task automatic compare_model();
    logic [CH-1:0] e_to;
    logic          e_hang;
    e_to = '0; e_hang = 1'b0;
    for (int c = 0; c < CH; c++) begin
      e_to[c] = m_to[c];
      e_hang  = e_hang | m_hung[c];
    end
    chk("timeout", 32'(timeout), 32'(e_to));
    chk("hang", 32'(hang), 32'(e_hang));
    chk("first_valid", 32'(first_valid), 32'(m_fv));
    chk("first_chan", 32'(first_chan), 32'(m_fc));
  endtask

  task automatic tick();
    @(posedge clk);
    n_edge++;
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load(input int ch, input int val);
    lv = 1'b1; lc = CHW'(ch); lval = CW'(val);
    tick();
    lv = 1'b0;
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    en = '0; kk = '0; lv = 1'b0;
    #1;
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_hang", 32'(hang), 32'd0);
    chk("rst_first_valid", 32'(first_valid), 32'd0);
    chk("rst_first_chan", 32'(first_chan), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; en = '0; kk = '0; lv = 1'b0; lc = '0; lval = '0;
    n_edge = 0;
    model_reset();
    #1;
    chk("init_timeout", 32'(timeout), 32'd0);
    chk("init_hang", 32'(hang), 32'd0);
    chk("init_first_valid", 32'(first_valid), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    // ch0 reload 3: timeout exactly 4 edges after the enable edge
    load(0, 3);
    en[0] = 1'b1; tick();
    ticks(3);
    chk("s1_early", 32'(timeout[0]), 32'd0);
    tick();
    chk("s1_expire", 32'(timeout[0]), 32'd1);
    chk("s1_first_valid", 32'(first_valid), 32'd1);
    chk("s1_first_chan", 32'(first_chan), 32'd0);
    en[0] = 1'b0; tick();

    // ch1 reload 5, kicked every 4 edges, then left to expire
    load(1, 5);
    en[1] = 1'b1; tick();
    for (int i = 0; i < 50; i++) begin
      kk[1] = (i % 4 == 0);
      tick();
    end
    kk[1] = 1'b0;
    chk("s2_kept_alive", 32'(timeout[1]), 32'd0);
    kk[1] = 1'b1; tick(); kk[1] = 1'b0;
    ticks(5);
    chk("s2_before", 32'(timeout[1]), 32'd0);
    tick();
    chk("s2_expire", 32'(timeout[1]), 32'd1);
    en[1] = 1'b0; tick();

    // ch2 expires with enable held, then hangs 101 edges later
    load(2, 2);
    en[2] = 1'b1; tick();
    ticks(3);
    chk("s3_expire", 32'(timeout[2]), 32'd1);
    ticks(100);
    chk("s3_no_hang_yet", 32'(hang), 32'd0);
    tick();
    chk("s3_hang", 32'(hang), 32'd1);
    en[2] = 1'b0; kk[2] = 1'b1; ticks(3); kk[2] = 1'b0;
    chk("s3_hang_sticky", 32'(hang), 32'd1);
    chk("s3_to_sticky", 32'(timeout[2]), 32'd1);
    do_reset();

    // ch2/ch3 same reload and enable edge: lowest index wins; out-of-range writes dropped
    load(2, 7); load(3, 7);
    en[2] = 1'b1; en[3] = 1'b1; tick();
    load(7, 1); load(5, 0); load(6, 2);
    ticks(5);
    chk("s4_both", 32'(timeout[3:2]), 32'd3);
    chk("s4_first_chan", 32'(first_chan), 32'd2);
    en = '0; tick();
    en[2] = 1'b1; en[3] = 1'b1; tick();
    ticks(7);
    chk("s4_reload_kept", 32'(timeout[3:2]), 32'd0);
    tick();
    chk("s4_reexpire", 32'(timeout[3:2]), 32'd3);
    en = '0; tick();

    // Same-edge write and kick: the restart uses the old reload, the next kick the new one
    load(0, 10);
    en[0] = 1'b1; tick();
    ticks(3);
    lv = 1'b1; lc = 3'd0; lval = 32'd20; kk[0] = 1'b1; tick();
    lv = 1'b0; kk[0] = 1'b0;
    ticks(4);
    kk[0] = 1'b1; tick(); kk[0] = 1'b0;
    ticks(20);
    chk("s5_new_reload_early", 32'(timeout[0]), 32'd0);
    tick();
    chk("s5_new_reload_expire", 32'(timeout[0]), 32'd1);
    en[0] = 1'b0; tick();

    // Reset mid-COUNT; the reload returns to its default value
    en[1] = 1'b1; ticks(4);
    do_reset();
    en[0] = 1'b1; tick();
    ticks(1000);
    chk("s6_default_early", 32'(timeout[0]), 32'd0);
    tick();
    chk("s6_default_expire", 32'(timeout[0]), 32'd1);
    do_reset();

    // Random phase
    for (int c = 0; c < CH; c++) load(c, $urandom_range(12));
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(19) == 0) en[c] = ~en[c];
        kk[c] = ($urandom_range(7) == 0);
      end
      lv   = ($urandom_range(9) == 0);
      lc   = CHW'($urandom_range(7));
      lval = CW'($urandom_range(12));
      if ($urandom_range(399) == 0) do_reset();
      else tick();
    end
    en = '0; kk = '0; lv = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
